writeback_buffer: RTL and testbench
===================================

Name: writeback_buffer

Overview:
- Parametrised successor to the single-entry writeback stage.
- Accepts completed instructions from the MEM stage through a valid/ready handshake.
- Formats load data with byte-lane select and sign/zero extension, and selects among ALU result, load data and link address.
- Queues results in a DEPTH-entry in-order buffer that drains into a shared register-file write port; also provides a youngest-first forwarding lookup and a retire counter.

Parameters:
- DATA_W, 64, datapath width; must be 32 or 64.
- REG_AW, 5, register address width.
- DEPTH, 2, buffer entries; power of two, at least 2.
- CNT_W, 32, retire counter width.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous reset, active-low
- in_valid  in  1  MEM stage presents an entry
- in_ready  out  1  buffer can accept an entry
- RegIn  in  REG_AW  destination register
- ResultIn  in  DATA_W  ALU result
- LoadDataIn  in  DATA_W  raw memory word
- LinkIn  in  DATA_W  PC+4 for link writes
- WbSel  in  2  source select: 00 result, 01 load, 10 link, 11 result
- LoadSize  in  2  size select: 00 byte, 01 half, 10 word, 11 dword
- LoadUnsigned  in  1  1 = zero-extend, 0 = sign-extend
- ByteOffset  in  log2(DATA_W/8)  byte address of the load within the word
- RegWriteIn  in  1  entry writes the register file
- wr_ready  in  1  register-file port free this cycle
- Reg2Write  out  REG_AW  head destination
- Data2Write  out  DATA_W  head data
- RegWriteEn  out  1  head write strobe
- fwd_query  in  REG_AW  register being looked up
- fwd_hit  out  1  a buffered entry matches fwd_query
- fwd_data  out  DATA_W  data of the youngest matching entry
- retire_count  out  CNT_W  entries retired since reset

Behaviour:
- Reset (rst_n low at a clock edge):
  - count, read and write pointers, and retire_count cleared to 0; all entries invalidated.
  - Following the edge: in_ready=1, RegWriteEn=0, Reg2Write=0, Data2Write=0, fwd_hit=0, fwd_data=0.
  - Reset mid-operation discards all buffered entries; none are written.
- Accept: push when in_valid && in_ready.
  - in_ready = (count < DEPTH), from registered state only; no combinational path from wr_ready.
  - A full buffer does not accept even if a pop occurs the same cycle.
- Formatting is done at accept; the buffer stores final data, destination and a write-needed bit.
  - write-needed = RegWriteIn && RegIn != 0.
- Load formatting (little-endian):
  - Size bytes = 1/2/4/8.
  - Effective offset = ByteOffset with the low log2(size) bits cleared (aligned down).
  - Extract size bytes starting at the effective offset; extend to DATA_W from the MSB of the extracted field (sign), or fill with zeros if LoadUnsigned.
  - When DATA_W=32, LoadSize 11 is treated as word. A full-width load ignores LoadUnsigned.
- Head output, all combinational from the head entry:
  - Reg2Write and Data2Write present head contents whenever count > 0; both 0 when empty.
  - RegWriteEn = (count>0) && head write-needed && wr_ready.
- Pop (retire) when count>0 && (wr_ready || !head write-needed). Entries that do not write retire without waiting for the port.
- Exactly one entry retires per cycle at most; push and pop may coincide, leaving count unchanged.
- Pointers wrap modulo DEPTH.
- retire_count increments by 1 per pop and wraps at 2^CNT_W.
- Forwarding (combinational):
  - Scan valid entries, youngest first, for write-needed && dest == fwd_query.
  - fwd_hit=1 with that entry's data on the first match.
  - A query of register 0 never hits. On a miss, fwd_data=0.
  - An entry being pushed this cycle is not visible to forwarding until the next cycle.
- Ordering: strictly in-order; register-file writes occur in acceptance order.

Test Plan:
- Reset then idle → in_ready=1, RegWriteEn=0, Reg2Write=0, Data2Write=0, retire_count=0.
- Push RegIn=3, WbSel=01, LoadSize=00, signed, ByteOffset=5, LoadDataIn=0x0000_80FF_0000_0000, wr_ready=1 → next cycle Data2Write=0xFFFF_FFFF_FFFF_FF80, RegWriteEn=1, Reg2Write=3; retire_count=1 after.
- Push halfword unsigned ByteOffset=3 (aligns to 2), LoadDataIn=0x0000_0000_1234_5678 → Data2Write=0x0000_0000_0000_1234.
- Hold wr_ready=0; push entries to r5=0xA, r5=0xB → in_ready=0 after 2 pushes (DEPTH=2); fwd_query=5 gives fwd_hit=1, fwd_data=0xB. Raise wr_ready → writes 0xA then 0xB on consecutive cycles, then in_ready=1.
- With wr_ready=0, push RegWriteIn=0 and then RegIn=0 with RegWriteIn=1 → both retire in consecutive cycles with RegWriteEn=0; retire_count +2; fwd_query=0 gives fwd_hit=0.
- With 2 entries buffered and wr_ready=0, drive rst_n=0 for one cycle → buffer empty, no RegWriteEn pulse, retire_count=0, in_ready=1.

Source files
------------

// File: rtl/writeback_buffer.sv
// In-order writeback buffer: formats MEM results at accept, drains to the RF port, forwards youngest match.
// Latency: one cycle accept-to-head; backpressure via in_ready (registered count only), head waits on wr_ready.
module writeback_buffer #(
  parameter int DATA_W = 64,
  parameter int REG_AW = 5,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = 32,
  localparam int OFF_W = $clog2(DATA_W / 8),
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [REG_AW-1:0] RegIn,
  input  logic [DATA_W-1:0] ResultIn,
  input  logic [DATA_W-1:0] LoadDataIn,
  input  logic [DATA_W-1:0] LinkIn,
  input  logic [1:0]        WbSel,
  input  logic [1:0]        LoadSize,
  input  logic              LoadUnsigned,
  input  logic [OFF_W-1:0]  ByteOffset,
  input  logic              RegWriteIn,
  input  logic              wr_ready,
  output logic [REG_AW-1:0] Reg2Write,
  output logic [DATA_W-1:0] Data2Write,
  output logic              RegWriteEn,
  input  logic [REG_AW-1:0] fwd_query,
  output logic              fwd_hit,
  output logic [DATA_W-1:0] fwd_data,
  output logic [CNT_W-1:0]  retire_count
);

  logic [REG_AW-1:0] dest_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]  wn_q;
  logic [AW-1:0]     rd_ptr, wr_ptr, idx;
  logic [AW:0]       count;
  logic              push, pop, head_wn;

  logic [1:0]        sz;
  logic [OFF_W-1:0]  eff;
  logic [6:0]        nbits;
  logic              sign;
  logic [DATA_W-1:0] shifted, mask, load_fmt, sel_data;

  assign in_ready = (count < (AW+1)'(DEPTH));
  assign head_wn  = wn_q[rd_ptr];
  assign push     = in_valid && in_ready;
  assign pop      = (count != '0) && (wr_ready || !head_wn);

  // Mask covers the extracted field; a full-width load yields an all-ones mask so no extension applies.
  always_comb begin
    sz = LoadSize;
    if (DATA_W == 32 && LoadSize == 2'b11) sz = 2'b10;
    eff     = (ByteOffset >> sz) << sz;
    shifted = LoadDataIn >> {eff, 3'b000};
    nbits   = 7'd8 << sz;
    mask    = ~({DATA_W{1'b1}} << nbits);
    case (sz)
      2'b00:   sign = shifted[7];
      2'b01:   sign = shifted[15];
      2'b10:   sign = shifted[31];
      default: sign = shifted[DATA_W-1];
    endcase
    load_fmt = shifted & mask;
    if (!LoadUnsigned && sign) load_fmt = load_fmt | ~mask;
    case (WbSel)
      2'b01:   sel_data = load_fmt;
      2'b10:   sel_data = LinkIn;
      default: sel_data = ResultIn;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      retire_count <= '0;
      wn_q         <= '0;
    end else begin
      if (push) begin
        wn_q[wr_ptr] <= RegWriteIn && (RegIn != '0);
        wr_ptr       <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr       <= rd_ptr + 1'b1;
        retire_count <= retire_count + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      dest_q[wr_ptr] <= RegIn;
      data_q[wr_ptr] <= sel_data;
    end
  end

  // Oldest-to-youngest scan: later matches overwrite earlier ones so the youngest wins.
  always_comb begin
    Reg2Write  = '0;
    Data2Write = '0;
    RegWriteEn = 1'b0;
    if (count != '0) begin
      Reg2Write  = dest_q[rd_ptr];
      Data2Write = data_q[rd_ptr];
      RegWriteEn = head_wn && wr_ready;
    end
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr + AW'(k);
      if (((AW+1)'(k) < count) && wn_q[idx] && (dest_q[idx] == fwd_query)) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[idx];
      end
    end
  end

endmodule

// File: tb/tb_writeback_buffer.sv
// Bench for writeback_buffer: directed scenarios plus random traffic against a queue-based reference model.
module tb_writeback_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [4:0]  RegIn;
  logic [63:0] ResultIn, LoadDataIn, LinkIn;
  logic [1:0]  WbSel, LoadSize;
  logic        LoadUnsigned;
  logic [2:0]  ByteOffset;
  logic        RegWriteIn, wr_ready;
  logic [4:0]  Reg2Write;
  logic [63:0] Data2Write;
  logic        RegWriteEn;
  logic [4:0]  fwd_query;
  logic        fwd_hit;
  logic [63:0] fwd_data;
  logic [31:0] retire_count;

  writeback_buffer dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .RegIn(RegIn), .ResultIn(ResultIn), .LoadDataIn(LoadDataIn), .LinkIn(LinkIn),
    .WbSel(WbSel), .LoadSize(LoadSize), .LoadUnsigned(LoadUnsigned), .ByteOffset(ByteOffset),
    .RegWriteIn(RegWriteIn), .wr_ready(wr_ready), .Reg2Write(Reg2Write), .Data2Write(Data2Write),
    .RegWriteEn(RegWriteEn), .fwd_query(fwd_query), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
    .retire_count(retire_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rg;
    logic [63:0] dat;
    logic        wn;
  } ent_t;

  ent_t mq[$];   // model of buffered entries, oldest first
  ent_t wq[$];   // expected register-file writes in order
  int   retired;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   chk_en = 1'b0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] fmt(logic [63:0] ld, logic [1:0] ls, logic uns, logic [2:0] bo);
    int n, off;
    logic [63:0] v, m;
    n   = 1 << ls;
    off = (int'(bo) / n) * n;
    v   = ld >> (8 * off);
    if (n == 8) return v;
    m = (64'd1 << (8 * n)) - 64'd1;
    v = v & m;
    if (!uns && v[8*n-1]) v = v | ~m;
    return v;
  endfunction

  function automatic logic [63:0] ref_data();
    case (WbSel)
      2'b01:   return fmt(LoadDataIn, LoadSize, LoadUnsigned, ByteOffset);
      2'b10:   return LinkIn;
      default: return ResultIn;
    endcase
  endfunction

  task automatic model_update();
    ent_t e;
    bit do_push, do_pop;
    if (!rst_n) begin
      mq.delete();
      wq.delete();
      retired = 0;
      return;
    end
    do_push = in_valid && (mq.size() < 2);
    do_pop  = (mq.size() > 0) && (wr_ready || !mq[0].wn);
    e.rg  = RegIn;
    e.dat = ref_data();
    e.wn  = RegWriteIn && (RegIn != 5'd0);
    if (do_pop) begin
      void'(mq.pop_front());
      retired++;
    end
    if (do_push) begin
      mq.push_back(e);
      if (e.wn) wq.push_back(e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_update();
  endtask

  task automatic push_ent(logic [4:0] rg, logic [1:0] sel, logic [63:0] res, logic [63:0] ld,
                          logic [1:0] ls, logic uns, logic [2:0] bo, logic we);
    RegIn = rg; WbSel = sel; ResultIn = res; LoadDataIn = ld;
    LoadSize = ls; LoadUnsigned = uns; ByteOffset = bo; RegWriteIn = we;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  // Monitor: compares DUT outputs to the model and pops the write scoreboard on each presented write.
  logic        exp_hit, exp_wen;
  logic [63:0] exp_fd, exp_d;
  logic [4:0]  exp_r;
  ent_t        got;
  always @(negedge clk) begin
    if (chk_en) begin
      exp_hit = 1'b0; exp_fd = '0; exp_wen = 1'b0; exp_r = '0; exp_d = '0;
      foreach (mq[i]) begin
        if (mq[i].wn && mq[i].rg == fwd_query) begin
          exp_hit = 1'b1;
          exp_fd  = mq[i].dat;
        end
      end
      if (mq.size() > 0) begin
        exp_r   = mq[0].rg;
        exp_d   = mq[0].dat;
        exp_wen = mq[0].wn && wr_ready;
      end
      chk("in_ready", 64'(in_ready), 64'(mq.size() < 2));
      chk("wr_en", 64'(RegWriteEn), 64'(exp_wen));
      chk("head_reg", 64'(Reg2Write), 64'(exp_r));
      chk("head_data", Data2Write, exp_d);
      chk("fwd_hit", 64'(fwd_hit), 64'(exp_hit));
      chk("fwd_data", fwd_data, exp_fd);
      chk("retire_count", 64'(retire_count), 64'(retired));
      if (RegWriteEn === 1'b1) begin
        if (wq.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL sb_unexpected_write: got reg %0d data %h expected no write", Reg2Write, Data2Write);
        end else begin
          got = wq.pop_front();
          chk("sb_reg", 64'(Reg2Write), 64'(got.rg));
          chk("sb_data", Data2Write, got.dat);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    int rc0;
    rst_n = 1'b0; in_valid = 1'b0; RegIn = '0; ResultIn = '0; LoadDataIn = '0; LinkIn = '0;
    WbSel = '0; LoadSize = '0; LoadUnsigned = 1'b0; ByteOffset = '0; RegWriteIn = 1'b0;
    wr_ready = 1'b0; fwd_query = '0;
    step();
    chk_en = 1'b1;
    step();
    rst_n = 1'b1;
    step();
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_wr_en", 64'(RegWriteEn), 64'd0);
    chk("reset_data", Data2Write, 64'd0);
    chk("reset_retire", 64'(retire_count), 64'd0);

    // signed byte load from offset 5
    wr_ready = 1'b1;
    push_ent(5'd3, 2'b01, 64'd0, 64'h0000_80FF_0000_0000, 2'b00, 1'b0, 3'd5, 1'b1);
    chk("t1_data", Data2Write, 64'hFFFF_FFFF_FFFF_FF80);
    chk("t1_reg", 64'(Reg2Write), 64'd3);
    chk("t1_wen", 64'(RegWriteEn), 64'd1);
    step();
    chk("t1_retire", 64'(retire_count), 64'd1);

    // unsigned halfword, offset 3 aligns down to 2
    push_ent(5'd4, 2'b01, 64'd0, 64'h0000_0000_1234_5678, 2'b01, 1'b1, 3'd3, 1'b1);
    chk("t2_data", Data2Write, 64'h0000_0000_0000_1234);
    step();

    // fill with two writes to r5, forward youngest, then drain in order
    wr_ready = 1'b0;
    push_ent(5'd5, 2'b00, 64'hA, 64'd0, 2'b00, 1'b0, 3'd0, 1'b1);
    push_ent(5'd5, 2'b00, 64'hB, 64'd0, 2'b00, 1'b0, 3'd0, 1'b1);
    chk("t3_full", 64'(in_ready), 64'd0);
    fwd_query = 5'd5;
    #1;
    chk("t3_fwd_hit", 64'(fwd_hit), 64'd1);
    chk("t3_fwd_data", fwd_data, 64'hB);
    chk("t3_head_first", Data2Write, 64'hA);
    fwd_query = 5'd0;
    wr_ready = 1'b1;
    step();
    chk("t3_head_second", Data2Write, 64'hB);
    step();
    chk("t3_ready_again", 64'(in_ready), 64'd1);

    // non-writing entries retire without the port
    wr_ready = 1'b0;
    rc0 = retired;
    push_ent(5'd7, 2'b00, 64'h77, 64'd0, 2'b00, 1'b0, 3'd0, 1'b0);
    push_ent(5'd0, 2'b00, 64'h99, 64'd0, 2'b00, 1'b0, 3'd0, 1'b1);
    #1;
    chk("t4_fwd_r0", 64'(fwd_hit), 64'd0);
    step();
    chk("t4_retire", 64'(retire_count), 64'(rc0 + 2));
    chk("t4_empty", 64'(RegWriteEn), 64'd0);

    // reset with two buffered entries
    push_ent(5'd9, 2'b10, 64'd0, 64'd0, 2'b00, 1'b0, 3'd0, 1'b1);
    LinkIn = 64'h1234;
    push_ent(5'd10, 2'b10, 64'd0, 64'd0, 2'b00, 1'b0, 3'd0, 1'b1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("t5_in_ready", 64'(in_ready), 64'd1);
    chk("t5_retire", 64'(retire_count), 64'd0);
    chk("t5_wen", 64'(RegWriteEn), 64'd0);
    wr_ready = 1'b1;
    step();
    step();

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      in_valid     = ($urandom_range(3, 0) != 0);
      wr_ready     = ($urandom_range(2, 0) != 0);
      RegIn        = 5'($urandom_range(7, 0));
      fwd_query    = 5'($urandom_range(7, 0));
      ResultIn     = {$urandom, $urandom};
      LoadDataIn   = {$urandom, $urandom};
      LinkIn       = {$urandom, $urandom};
      WbSel        = 2'($urandom_range(3, 0));
      LoadSize     = 2'($urandom_range(3, 0));
      LoadUnsigned = 1'($urandom_range(1, 0));
      ByteOffset   = 3'($urandom_range(7, 0));
      RegWriteIn   = ($urandom_range(4, 0) != 0);
      step();
    end

    in_valid = 1'b0;
    wr_ready = 1'b1;
    for (int i = 0; i < 8; i++) step();
    chk("drain_ready", 64'(in_ready), 64'd1);
    chk("sb_leftover", 64'(wq.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
